// File: rtl/rca64_operand_loader_if.sv
// Bus bundle between the operand loader and its environment: word stream in, adder operands/results, result stream out.
// RCA_LOADER_OVF_EN adds the out_ovf signed-overflow flag.
interface rca64_operand_loader_if #(
    parameter int WORD_W = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_data;
    logic              in_cin;
    logic [63:0]       add_a;
    logic [63:0]       add_b;
    logic              add_cin;
    logic [63:0]       add_s;
    logic              add_cout;
    logic              out_valid;
    logic              out_ready;
    logic [63:0]       out_sum;
    logic              out_cout;
`ifdef RCA_LOADER_OVF_EN
    logic              out_ovf;
`endif

    // master: word source, adder and result sink; slave: the loader itself
    modport master (
        output in_valid, in_data, in_cin, add_s, add_cout, out_ready,
        input  in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_cout
`ifdef RCA_LOADER_OVF_EN
        , input out_ovf
`endif
    );

    modport slave (
        input  in_valid, in_data, in_cin, add_s, add_cout, out_ready,
        output in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_cout
`ifdef RCA_LOADER_OVF_EN
        , output out_ovf
`endif
    );
endinterface

// File: rtl/rca64_operand_loader.sv
// Front end of the 64-bit ripple-carry adder: builds A/B from a 16-bit word stream, waits out the carry ripple,
// then registers S/Cout for a valid/ready result port. Optional RCA_LOADER_OVF_EN adds a signed-overflow flag.
module rca64_operand_loader #(
    parameter int WORD_W        = 16,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rca64_operand_loader_if.slave bus
);

    localparam logic [1:0] LOAD_A = 2'd0;
    localparam logic [1:0] LOAD_B = 2'd1;
    localparam logic [1:0] SETTLE = 2'd2;
    localparam logic [1:0] HOLD   = 2'd3;

    localparam int               CNT_W       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [1:0]       LAST_WORD   = 2'd3;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [1:0]       word_idx;
    logic [CNT_W-1:0] settle_cnt;
    logic             accept;
    logic             last_word;
    logic             capture;
    logic             release_res;

    assign accept      = bus.in_valid & bus.in_ready;
    assign last_word   = (word_idx == LAST_WORD);
    assign capture     = (state == SETTLE) && (settle_cnt == SETTLE_LAST);
    assign release_res = (state == HOLD) && bus.out_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            LOAD_A:  if (accept && last_word) state_nxt = LOAD_B;
            LOAD_B:  if (accept && last_word) state_nxt = SETTLE;
            SETTLE:  if (capture)             state_nxt = HOLD;
            HOLD:    if (bus.out_ready)       state_nxt = LOAD_A;
            default:                          state_nxt = LOAD_A;
        endcase
    end

    // in_ready is registered from the next state so it stays low through reset and rises on the first edge after it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= LOAD_A;
            word_idx     <= 2'd0;
            settle_cnt   <= '0;
            bus.in_ready <= 1'b0;
        end else begin
            state        <= state_nxt;
            bus.in_ready <= (state_nxt == LOAD_A) || (state_nxt == LOAD_B);
            if (accept) begin
                word_idx <= word_idx + 2'd1;
            end
            if (state == SETTLE) begin
                settle_cnt <= settle_cnt + CNT_W'(1);
            end else begin
                settle_cnt <= '0;
            end
        end
    end

    // Operands only change on accepted words, so they are quiet for the whole settle window
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.add_a   <= '0;
            bus.add_b   <= '0;
            bus.add_cin <= 1'b0;
        end else if (accept) begin
            if (state == LOAD_A) begin
                bus.add_a[WORD_W*word_idx +: WORD_W] <= bus.in_data;
                if (word_idx == 2'd0) begin
                    bus.add_cin <= bus.in_cin;
                end
            end else if (state == LOAD_B) begin
                bus.add_b[WORD_W*word_idx +: WORD_W] <= bus.in_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_sum   <= '0;
            bus.out_cout  <= 1'b0;
        end else if (capture) begin
            bus.out_valid <= 1'b1;
            bus.out_sum   <= bus.add_s;
            bus.out_cout  <= bus.add_cout;
        end else if (release_res) begin
            bus.out_valid <= 1'b0;
        end
    end

`ifdef RCA_LOADER_OVF_EN
    // Signed overflow: like-signed operands whose sum flips sign
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_ovf <= 1'b0;
        end else if (capture) begin
            bus.out_ovf <= (bus.add_a[63] == bus.add_b[63]) && (bus.add_s[63] != bus.add_a[63]);
        end else if (release_res) begin
            bus.out_ovf <= 1'b0;
        end
    end
`else
`endif

endmodule

// File: tb/tb_rca64_operand_loader.sv
// Testbench for rca64_operand_loader: directed vector table, mid-load reset sequence and random operand pairs
// checked against a plain-arithmetic adder model.
module tb_rca64_operand_loader;

    localparam int SETTLE   = 4;
    localparam int WAIT_MAX = 60;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rca64_operand_loader_if #(.WORD_W(16)) bus ();

    rca64_operand_loader #(
        .WORD_W        (16),
        .SETTLE_CYCLES (SETTLE)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Behavioural stand-in for the ripple-carry adder
    assign {bus.add_cout, bus.add_s} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {64'd0, bus.add_cin};

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        cin;
        logic [63:0] expSum;
        logic        expCout;
        logic        expOvf;
        int          holdCycles;
        bit          toggle;
        bit          junk;
        bit          earlyReady;
    } vec_t;

    int   total = 0;
    int   bad   = 0;
    vec_t vecs[6];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%016h want 0x%016h", name, act, exp);
        end
    endtask

    function automatic vec_t modelCase(input logic [63:0] a, input logic [63:0] b, input logic cin);
        vec_t        v;
        logic [64:0] full;
        full         = {1'b0, a} + {1'b0, b} + {64'd0, cin};
        v.a          = a;
        v.b          = b;
        v.cin        = cin;
        v.expSum     = full[63:0];
        v.expCout    = full[64];
        v.expOvf     = (a[63] == b[63]) && (full[63] != a[63]);
        v.holdCycles = int'($urandom_range(0, 12));
        v.toggle     = 1'($urandom_range(0, 1));
        v.junk       = 1'($urandom_range(0, 1));
        v.earlyReady = 1'($urandom_range(0, 1));
        return v;
    endfunction

    task automatic sendWord(input logic [15:0] w, input logic c);
        int guard = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        bus.in_cin   = c;
        while (bus.in_ready !== 1'b1 && guard < WAIT_MAX) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("word_accepted", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Eight words, A then B, least-significant first; in_cin is inverted on every word but the first
    task automatic applyStimulus(input logic [63:0] a, input logic [63:0] b, input logic cin, input bit toggle);
        logic [127:0] ops;
        ops = {b, a};
        for (int i = 0; i < 8; i++) begin
            sendWord(ops[16*i +: 16], (i == 0) ? cin : ~cin);
            if (toggle && i != 7) @(negedge clk);
        end
    endtask

    task automatic runCase(input vec_t v);
        int          cyc;
        bit          stableOk;
        logic [63:0] a0;
        logic [63:0] b0;
        logic [63:0] s0;
        logic        c0;
        bus.out_ready = v.earlyReady;
        applyStimulus(v.a, v.b, v.cin, v.toggle);
        bus.out_ready = 1'b0;
        if (v.junk) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 16'hDEAD;
            bus.in_cin   = 1'b1;
        end
        a0 = bus.add_a;
        b0 = bus.add_b;
        checkOutput("operand_a", a0, v.a);
        checkOutput("operand_b", b0, v.b);
        checkOutput("operand_cin", 64'(bus.add_cin), 64'(v.cin));
        cyc      = 0;
        stableOk = 1'b1;
        while (bus.out_valid !== 1'b1 && cyc < WAIT_MAX) begin
            @(negedge clk);
            cyc++;
            if (bus.add_a !== a0 || bus.add_b !== b0 || bus.in_ready !== 1'b0) stableOk = 1'b0;
        end
        checkOutput("latency", 64'(cyc), 64'(SETTLE));
        checkOutput("sum", bus.out_sum, v.expSum);
        checkOutput("cout", 64'(bus.out_cout), 64'(v.expCout));
`ifdef RCA_LOADER_OVF_EN
        checkOutput("ovf", 64'(bus.out_ovf), 64'(v.expOvf));
`endif
        s0 = bus.out_sum;
        c0 = bus.out_cout;
        for (int k = 0; k < v.holdCycles; k++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b1 || bus.out_sum !== s0 || bus.out_cout !== c0 || bus.in_ready !== 1'b0)
                stableOk = 1'b0;
        end
        checkOutput("settle_hold_stable", 64'(stableOk), 64'd1);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        checkOutput("release_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("release_ready", 64'(bus.in_ready), 64'd1);
`ifdef RCA_LOADER_OVF_EN
        checkOutput("release_ovf", 64'(bus.out_ovf), 64'd0);
`endif
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_in_ready"}, 64'(bus.in_ready), 64'd0);
        checkOutput({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
        checkOutput({tag, "_add_a"}, bus.add_a, 64'd0);
        checkOutput({tag, "_add_b"}, bus.add_b, 64'd0);
        checkOutput({tag, "_add_cin"}, 64'(bus.add_cin), 64'd0);
        checkOutput({tag, "_out_sum"}, bus.out_sum, 64'd0);
        checkOutput({tag, "_out_cout"}, 64'(bus.out_cout), 64'd0);
`ifdef RCA_LOADER_OVF_EN
        checkOutput({tag, "_out_ovf"}, 64'(bus.out_ovf), 64'd0);
`endif
    endtask

    initial begin
        vec_t v;
        bus.in_valid  = 1'b0;
        bus.in_data   = 16'd0;
        bus.in_cin    = 1'b0;
        bus.out_ready = 1'b0;

        vecs[0] = '{64'h0000_0000_0000_0001, 64'h0000_0000_0000_0002, 1'b0,
                    64'h0000_0000_0000_0003, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0000, 1'b1,
                    64'h0000_0000_0000_0000, 1'b1, 1'b0, 2, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b0,
                    64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 10, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{64'hDEAD_BEEF_0000_0000, 64'h2152_4110_FFFF_FFFF, 1'b1,
                    64'h0000_0000_0000_0000, 1'b1, 1'b0, 3, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0,
                    64'h8000_0000_0000_0000, 1'b0, 1'b1, 1, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0,
                    64'h0000_0000_0000_0000, 1'b1, 1'b1, 0, 1'b1, 1'b0, 1'b0};

        repeat (2) @(negedge clk);
        checkResetValues("reset");
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("ready_after_reset", 64'(bus.in_ready), 64'd1);

        $display("[TB] directed vectors");
        for (int i = 0; i < 6; i++) begin
            runCase(vecs[i]);
        end

        $display("[TB] reset in the middle of LOAD_B");
        for (int i = 0; i < 6; i++) begin
            sendWord((i < 4) ? 16'hA5A5 : 16'h5A5A, 1'b1);
        end
        #2 rst_n = 1'b0;
        #1 checkResetValues("midload");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("ready_after_midload", 64'(bus.in_ready), 64'd1);
        runCase(vecs[0]);

        $display("[TB] random operand pairs");
        for (int i = 0; i < 20; i++) begin
            v = modelCase({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
            runCase(v);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
